cache_main_memory: RTL and testbench

Block-addressed main-memory responder on the far side of the direct-mapped write-through cache. Serves 128-bit block reads (cache miss refill) and 128-bit block writes (write-through of the updated block) over a single-request handshake with configurable access latency. Holds 1024 bytes as 64 blocks of 16 bytes and replaces the current zero-latency combinational memory model so the cache can be exercised against realistic miss timing.

---
 rtl/cache_mem_pkg.sv | 37 +++
 rtl/mem_block_array.sv | 36 +++
 rtl/cache_main_memory.sv | 125 ++++++++++++
 tb/tb_cache_main_memory.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_mem_pkg.sv
// Shared types and constants for the block-addressed main-memory responder.
package cache_mem_pkg;

   localparam int unsigned ADDR_W          = 10;
   localparam int unsigned BLOCK_W         = 128;
   localparam int unsigned BLOCK_IDX_W     = 6;
   localparam int unsigned NUM_BLOCKS      = 64;
   localparam int unsigned BYTES_PER_BLOCK = 16;
   localparam int unsigned CNT_W           = 4;
   localparam int unsigned STAT_W          = 16;

   localparam logic OP_READ  = 1'b0;
   localparam logic OP_WRITE = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } mem_state_e;

   typedef struct packed {
      logic                   rw;
      logic [BLOCK_IDX_W-1:0] idx;
      logic [BLOCK_W-1:0]     wdata;
   } mem_req_t;

   // Power-on contents: the byte at address a holds a[7:0]; byte offset 0 is the MSB lane.
   function automatic logic [BLOCK_W-1:0] reset_block(input logic [BLOCK_IDX_W-1:0] idx);
      logic [BLOCK_W-1:0] blk;
      blk = '0;
      for (int unsigned i = 0; i < BYTES_PER_BLOCK; i++) begin
         blk[BLOCK_W-1-8*i -: 8] = 8'({idx, 4'(i)});
      end
      return blk;
   endfunction

endpackage

// File: rtl/mem_block_array.sv
// 64 x 128-bit single-port block store with registered read port; reset reloads the address pattern.
module mem_block_array
   import cache_mem_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   we_i,
   input  logic                   re_i,
   input  logic [BLOCK_IDX_W-1:0] idx_i,
   input  logic [BLOCK_W-1:0]     wdata_i,
   output logic [BLOCK_W-1:0]     rdata_o
);

   logic [BLOCK_W-1:0] mem_q [NUM_BLOCKS];
   logic [BLOCK_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned b = 0; b < NUM_BLOCKS; b++) begin
            mem_q[b] <= reset_block(BLOCK_IDX_W'(b));
         end
         rdata_q <= '0;
      end else begin
         if (we_i) begin
            mem_q[idx_i] <= wdata_i;
         end
         // Read register only moves on reads, so a write response leaves it untouched.
         if (re_i) begin
            rdata_q <= mem_q[idx_i];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/cache_main_memory.sv
// Main-memory responder: single-request handshake, LATENCY-cycle block access.
// Optional per-direction access counters when CACHE_MAIN_MEMORY_STATS_EN is defined.
module cache_main_memory
   import cache_mem_pkg::*;
#(
   parameter int unsigned LATENCY = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req,
   input  logic               read_write,
   input  logic [ADDR_W-1:0]  addr,
   input  logic [BLOCK_W-1:0] writedata,
   output logic [BLOCK_W-1:0] readdata,
   output logic               ready,
   output logic               busy
`ifdef CACHE_MAIN_MEMORY_STATS_EN
   ,
   output logic [STAT_W-1:0]  rd_count,
   output logic [STAT_W-1:0]  wr_count
`endif
);

   mem_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   mem_req_t           req_q, req_d;
   logic               ready_q, ready_d;
   logic               busy_q, busy_d;
   logic               arr_we, arr_re;
   logic               unused_addr_offset;

   assign unused_addr_offset = ^addr[ADDR_W-BLOCK_IDX_W-1:0];

   // Next-state: the completion cycle also samples req, so back-to-back
   // requests sustain one block every LATENCY+1 cycles.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      ready_d = 1'b0;
      busy_d  = busy_q;
      arr_we  = 1'b0;
      arr_re  = 1'b0;
      case (state_q)
         IDLE, RESP: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            if (req) begin
               req_d.rw    = read_write;
               req_d.idx   = addr[ADDR_W-1 -: BLOCK_IDX_W];
               req_d.wdata = writedata;
               cnt_d       = CNT_W'(LATENCY - 1);
               state_d     = BUSY;
               busy_d      = 1'b1;
            end
         end
         BUSY: begin
            if (cnt_q != '0) begin
               cnt_d = CNT_W'(cnt_q - 1'b1);
            end else begin
               arr_we  = (req_q.rw == OP_WRITE);
               arr_re  = (req_q.rw == OP_READ);
               ready_d = 1'b1;
               state_d = RESP;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         req_q   <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
      end
   end

   mem_block_array u_array (
      .clk     (clk),
      .rst     (rst),
      .we_i    (arr_we),
      .re_i    (arr_re),
      .idx_i   (req_q.idx),
      .wdata_i (req_q.wdata),
      .rdata_o (readdata)
   );

   assign ready = ready_q;
   assign busy  = busy_q;

`ifdef CACHE_MAIN_MEMORY_STATS_EN
   logic [STAT_W-1:0] rd_count_q, wr_count_q;

   // Saturating counters bumped on the commit edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_count_q <= '0;
         wr_count_q <= '0;
      end else begin
         if (arr_re && (rd_count_q != {STAT_W{1'b1}})) begin
            rd_count_q <= STAT_W'(rd_count_q + 1'b1);
         end
         if (arr_we && (wr_count_q != {STAT_W{1'b1}})) begin
            wr_count_q <= STAT_W'(wr_count_q + 1'b1);
         end
      end
   end

   assign rd_count = rd_count_q;
   assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_cache_main_memory.sv
// Bench for cache_main_memory: timing/content model plus directed literal checks.
module tb_cache_main_memory;

   localparam int unsigned L = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         req, read_write;
   logic [9:0]   addr;
   logic [127:0] writedata, readdata;
   logic         ready, busy;
   logic         req1, rw1;
   logic [9:0]   addr1;
   logic [127:0] wd1, readdata1;
   logic         ready1, busy1;
`ifdef CACHE_MAIN_MEMORY_STATS_EN
   logic [15:0]  rd_count, wr_count, unused_rd_count1, unused_wr_count1;
`endif

   always #5 clk = ~clk;

   cache_main_memory #(.LATENCY(L)) u_dut (
      .clk(clk), .rst(rst), .req(req), .read_write(read_write), .addr(addr),
      .writedata(writedata), .readdata(readdata), .ready(ready), .busy(busy)
`ifdef CACHE_MAIN_MEMORY_STATS_EN
      , .rd_count(rd_count), .wr_count(wr_count)
`endif
   );

   cache_main_memory #(.LATENCY(1)) u_dut1 (
      .clk(clk), .rst(rst), .req(req1), .read_write(rw1), .addr(addr1),
      .writedata(wd1), .readdata(readdata1), .ready(ready1), .busy(busy1)
`ifdef CACHE_MAIN_MEMORY_STATS_EN
      , .rd_count(unused_rd_count1), .wr_count(unused_wr_count1)
`endif
   );

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   // Model: edge numbers of acceptance/completion plus a plain block array.
   logic [127:0] m_mem [64];
   logic [127:0] m_rd = '0;
   logic         m_rw = 1'b0;
   logic [5:0]   m_idx = '0;
   logic [127:0] m_wd = '0;
   int cyc = 0;
   int m_acc = -100;
   int m_done = -100;
   int m_free = 0;
   int m_rdc = 0;
   int m_wrc = 0;

   function automatic logic [127:0] pattern(input int b);
      logic [127:0] v;
      v = '0;
      for (int off = 0; off < 16; off++) v[127-8*off -: 8] = 8'((b * 16 + off) % 256);
      return v;
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         for (int b = 0; b < 64; b++) m_mem[b] <= pattern(b);
         m_rd   <= '0;
         m_acc  <= -100;
         m_done <= -100;
         m_free <= cyc + 1;
         m_rdc  <= 0;
         m_wrc  <= 0;
      end else begin
         if (cyc == m_done) begin
            if (m_rw) begin
               m_mem[m_idx] <= m_wd;
               if (m_wrc < 65535) m_wrc <= m_wrc + 1;
            end else begin
               m_rd <= m_mem[m_idx];
               if (m_rdc < 65535) m_rdc <= m_rdc + 1;
            end
         end
         if (cyc >= m_free && req) begin
            m_acc  <= cyc;
            m_done <= cyc + L;
            m_free <= cyc + L + 1;
            m_rw   <= read_write;
            m_idx  <= addr[9:4];
            m_wd   <= writedata;
         end
      end
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic compare();
      int e;
      e = cyc - 1;
      chk("model_ready", 128'(ready), 128'(e == m_done));
      chk("model_busy", 128'(busy), 128'(e >= m_acc && e <= m_done));
      chk("model_readdata", readdata, m_rd);
`ifdef CACHE_MAIN_MEMORY_STATS_EN
      chk("model_rd_count", 128'(rd_count), 128'(m_rdc));
      chk("model_wr_count", 128'(wr_count), 128'(m_wrc));
`endif
   endtask

   // Issue one request, drop req once busy is seen, return negedges to ready and readdata then.
   task automatic issue(input logic rw, input logic [9:0] a, input logic [127:0] wd,
                        output int lat, output logic [127:0] rdv);
      @(negedge clk);
      req = 1'b1; read_write = rw; addr = a; writedata = wd;
      lat = 0; rdv = '0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (busy) req = 1'b0;
         if (ready) begin
            lat = i;
            rdv = readdata;
            break;
         end
      end
      req = 1'b0;
      if (lat == 0) chk("ready_timeout", 128'(0), 128'(1));
   endtask

   initial begin
      int           lat, cnt;
      logic [127:0] rdv;
      logic [31:0]  mask;

      rst = 1'b1; req = 1'b0; read_write = 1'b0; addr = '0; writedata = '0;
      req1 = 1'b0; rw1 = 1'b0; addr1 = '0; wd1 = '0;
      fork
         forever begin
            @(negedge clk);
            if (chk_en) compare();
         end
      join_none

      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset_readdata", readdata, 128'h0);
      chk("reset_ready", 128'(ready), 128'(0));
      chk("reset_busy", 128'(busy), 128'(0));
      chk("reset_readdata_l1", readdata1, 128'h0);
      chk_en = 1'b1;

      issue(1'b0, 10'h025, '0, lat, rdv);
      chk("read_latency", 128'(lat), 128'(L + 1));
      chk("read_blk2", rdv, 128'h202122232425262728292A2B2C2D2E2F);

      issue(1'b1, 10'h3F0, 128'hDEADBEEF_00000000_CAFEF00D_12345678, lat, rdv);
      chk("write_keeps_readdata", rdv, 128'h202122232425262728292A2B2C2D2E2F);
      issue(1'b0, 10'h3FC, '0, lat, rdv);
      chk("raw_blk63", rdv, 128'hDEADBEEF_00000000_CAFEF00D_12345678);

      // req held through a whole read: one extra access at the completion edge.
      @(negedge clk);
      req = 1'b1; read_write = 1'b0; addr = 10'h025;
      mask = '0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (i == 6) req = 1'b0;
         if (ready) mask[i] = 1'b1;
      end
      chk("held_req_ready_mask", 128'(mask), 128'(32'h0000_0420));
      chk("held_req_data", readdata, 128'h202122232425262728292A2B2C2D2E2F);

      // Reset during a pending write to block 5 discards it.
      @(negedge clk);
      req = 1'b1; read_write = 1'b1; addr = 10'h050; writedata = {4{32'hFFFF_FFFF}};
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      cnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (ready) cnt++;
      end
      chk("abort_no_ready", 128'(cnt), 128'(0));
      chk("abort_idle", 128'(busy), 128'(0));
      issue(1'b0, 10'h055, '0, lat, rdv);
      chk("abort_blk5_pattern", rdv, 128'h505152535455565758595A5B5C5D5E5F);

      // LATENCY=1 instance: ready after N+1, back-to-back every 2 cycles.
      @(negedge clk);
      req1 = 1'b1; rw1 = 1'b0; addr1 = 10'h000;
      mask = '0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (i == 1) chk("l1_busy", 128'(busy1), 128'(1));
         if (i == 2) chk("l1_data", readdata1, 128'h000102030405060708090A0B0C0D0E0F);
         if (i == 5) req1 = 1'b0;
         if (ready1) mask[i] = 1'b1;
      end
      chk("l1_ready_mask", 128'(mask), 128'(32'h0000_0054));

`ifdef CACHE_MAIN_MEMORY_STATS_EN
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      issue(1'b0, 10'h000, '0, lat, rdv);
      issue(1'b1, 10'h030, 128'h1, lat, rdv);
      issue(1'b0, 10'h010, '0, lat, rdv);
      issue(1'b1, 10'h040, 128'h2, lat, rdv);
      issue(1'b0, 10'h020, '0, lat, rdv);
      @(negedge clk);
      chk("stats_rd3", 128'(rd_count), 128'(3));
      chk("stats_wr2", 128'(wr_count), 128'(2));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("stats_rd_clr", 128'(rd_count), 128'(0));
      chk("stats_wr_clr", 128'(wr_count), 128'(0));
`endif

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
